// File: rtl/pattern_player_misr.sv
// Stimulus/response engine for combinational benchmark cores: replays a loadable
// vector memory into the core and folds the core's outputs into a MISR signature.
module pattern_player_misr #(
    parameter int VEC_WIDTH   = 36,
    parameter int RESP_WIDTH  = 7,
    parameter int DEPTH       = 16,
    parameter int HOLD_CYCLES = 1,
    parameter logic [RESP_WIDTH-1:0] MISR_POLY = 7'h03
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_en,
    input  logic [$clog2(DEPTH)-1:0]   load_addr,
    input  logic [VEC_WIDTH-1:0]       load_data,
    input  logic                       start,
    input  logic                       abort,
    input  logic [$clog2(DEPTH):0]     num_vec,
    input  logic                       loop_mode,
    output logic [VEC_WIDTH-1:0]       vec_out,
    output logic                       vec_valid,
    input  logic [RESP_WIDTH-1:0]      resp_in,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   vec_index,
    output logic [15:0]                pass_count,
    output logic [RESP_WIDTH-1:0]      signature
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [VEC_WIDTH-1:0]    mem [DEPTH];
    logic [AW:0]             n_eff;
    logic [AW:0]             n_clamped;
    logic                    loop_r;
    logic [HW-1:0]           hold_cnt;
    logic [AW-1:0]           idx_inc;
    logic                    sample;
    logic                    last_vec;
    logic [RESP_WIDTH-1:0]   sig_next;

    assign n_clamped = (num_vec > DEPTH_W) ? DEPTH_W : num_vec;
    assign idx_inc   = vec_index + AW'(1);
    assign sample    = (hold_cnt == HOLD_LAST);
    assign last_vec  = ({1'b0, vec_index} == (n_eff - (AW+1)'(1)));
    assign sig_next  = {signature[RESP_WIDTH-2:0], 1'b0}
                     ^ (signature[RESP_WIDTH-1] ? MISR_POLY : '0)
                     ^ resp_in;

    // Vector memory has no reset so contents survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (load_en && !busy)
            mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Abort is checked before the last-vector exit so it always wins.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start)
                    state_next = (n_clamped == '0) ? DONE : APPLY;
            end
            APPLY: begin
                if (abort)
                    state_next = DONE;
                else if (sample && last_vec && !loop_r)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        vec_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            APPLY: begin
                vec_valid = 1'b1;
                busy      = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // The read address is one step ahead so vec_out flips exactly at window ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_out    <= '0;
            vec_index  <= '0;
            pass_count <= '0;
            signature  <= '0;
            hold_cnt   <= '0;
            n_eff      <= '0;
            loop_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_eff      <= n_clamped;
                        loop_r     <= loop_mode;
                        signature  <= '0;
                        vec_index  <= '0;
                        pass_count <= '0;
                        hold_cnt   <= '0;
                        if (n_clamped != '0)
                            vec_out <= mem[0];
                    end
                end
                APPLY: begin
                    if (!abort) begin
                        if (sample) begin
                            hold_cnt  <= '0;
                            signature <= sig_next;
                            if (last_vec) begin
                                if (loop_r) begin
                                    vec_index  <= '0;
                                    vec_out    <= mem[0];
                                    pass_count <= pass_count + 16'd1;
                                end
                            end else begin
                                vec_index <= idx_inc;
                                vec_out   <= mem[idx_inc];
                            end
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_player_misr.sv
// Scoreboard bench for pattern_player_misr: a stub core feeds responses back and an
// abstract model predicts the vector stream, done timing, pass count and signature.
module tb_pattern_player_misr;

    localparam int VW         = 36;
    localparam int RW         = 7;
    localparam int DEPTH      = 16;
    localparam int HOLD       = 3;
    localparam int AW         = 4;
    localparam int WAIT_LIMIT = 600;
    localparam logic [RW-1:0] POLY = 7'h03;

    logic            clk = 1'b0;
    logic            rst;
    logic            load_en;
    logic [AW-1:0]   load_addr;
    logic [VW-1:0]   load_data;
    logic            start;
    logic            abort;
    logic [AW:0]     num_vec;
    logic            loop_mode;
    logic [VW-1:0]   vec_out;
    logic            vec_valid;
    logic [RW-1:0]   resp_in;
    logic            busy;
    logic            done;
    logic [AW-1:0]   vec_index;
    logic [15:0]     pass_count;
    logic [RW-1:0]   signature;

    typedef struct {
        logic [VW-1:0] vec;
        logic [AW-1:0] idx;
    } vec_exp_t;

    typedef struct {
        int            cyc;
        logic [RW-1:0] sig;
        logic [15:0]   pass;
        logic          chk_vec;
        logic [VW-1:0] last;
    } done_exp_t;

    vec_exp_t      exp_vec_q[$];
    done_exp_t     exp_done_q[$];
    vec_exp_t      ve;
    done_exp_t     de;
    logic [VW-1:0] mem_m [DEPTH];
    logic [RW-1:0] last_sig;
    int            tests = 0;
    int            fails = 0;
    int            cyc   = 0;
    logic          mon_en = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [RW-1:0] core(input logic [VW-1:0] v);
        return v[6:0] ^ v[35:29];
    endfunction

    assign resp_in = core(vec_out);

    pattern_player_misr #(
        .VEC_WIDTH(VW), .RESP_WIDTH(RW), .DEPTH(DEPTH),
        .HOLD_CYCLES(HOLD), .MISR_POLY(POLY)
    ) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .abort(abort), .num_vec(num_vec),
        .loop_mode(loop_mode), .vec_out(vec_out), .vec_valid(vec_valid),
        .resp_in(resp_in), .busy(busy), .done(done), .vec_index(vec_index),
        .pass_count(pass_count), .signature(signature)
    );

    // Signature as polynomial arithmetic: multiply by x, reduce by x^7 + POLY, add response.
    function automatic logic [RW-1:0] misrStep(input logic [RW-1:0] s, input logic [RW-1:0] r);
        int t;
        t = int'(s) * 2;
        if (t >= 128)
            t = t ^ (128 + int'(POLY));
        return RW'(t) ^ r;
    endfunction

    function automatic int clampN(input int n);
        return (n > DEPTH) ? DEPTH : n;
    endfunction

    function automatic logic [VW-1:0] randVec();
        return {4'($urandom()), 32'($urandom())};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void pushStream(input int n, input int cycles);
        vec_exp_t e;
        for (int c = 0; c < cycles; c++) begin
            e.vec = mem_m[(c / HOLD) % n];
            e.idx = AW'((c / HOLD) % n);
            exp_vec_q.push_back(e);
        end
    endfunction

    // abort_d = number of edges after the start edge at which abort is sampled (0 = none).
    function automatic void pushRun(input int t, input int n, input logic lp, input int abort_d);
        int            cycles;
        int            resp;
        done_exp_t     d;
        logic [RW-1:0] s;
        s = '0;
        if (n == 0) begin
            cycles = 0;
            resp   = 0;
            d.cyc  = t;
        end else if (abort_d > 0) begin
            cycles = abort_d;
            resp   = (abort_d - 1) / HOLD;
            d.cyc  = t + abort_d;
        end else begin
            cycles = n * HOLD;
            resp   = n;
            d.cyc  = t + n * HOLD;
        end
        if (n > 0)
            pushStream(n, cycles);
        for (int j = 0; j < resp; j++)
            s = misrStep(s, core(mem_m[j % n]));
        d.sig     = s;
        d.pass    = (lp && n > 0) ? 16'(resp / n) : 16'd0;
        d.chk_vec = (n > 0) && (abort_d == 0);
        d.last    = (n > 0) ? mem_m[n - 1] : '0;
        last_sig  = s;
        exp_done_q.push_back(d);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (vec_valid === 1'b1) begin
                if (exp_vec_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL vec_unexpected: vec_valid high with vec_out 0x%0h, expected no active vector (cycle %0d)", vec_out, cyc);
                end else begin
                    ve = exp_vec_q.pop_front();
                    checkOutput("vec_out", 64'(vec_out), 64'(ve.vec));
                    checkOutput("vec_index", 64'(vec_index), 64'(ve.idx));
                    checkOutput("busy_active", 64'(busy), 64'(1));
                end
            end
            if (done === 1'b1) begin
                if (exp_done_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL done_unexpected: done high, expected low (cycle %0d)", cyc);
                end else begin
                    de = exp_done_q.pop_front();
                    checkOutput("done_cycle", 64'(cyc), 64'(de.cyc));
                    checkOutput("done_sig", 64'(signature), 64'(de.sig));
                    checkOutput("done_pass", 64'(pass_count), 64'(de.pass));
                    checkOutput("done_busy", 64'(busy), 64'(0));
                    checkOutput("done_vec_valid", 64'(vec_valid), 64'(0));
                    checkOutput("stream_left", 64'(exp_vec_q.size()), 64'(0));
                    if (de.chk_vec)
                        checkOutput("done_vec_out", 64'(vec_out), 64'(de.last));
                end
            end
        end
    end

    task automatic loadMem(input int a, input logic [VW-1:0] d);
        load_en   = 1'b1;
        load_addr = AW'(a);
        load_data = d;
        @(posedge clk); #1;
        load_en   = 1'b0;
        mem_m[a]  = d;
    endtask

    // Load attempts issued while a run is active; the model memory is left untouched.
    task automatic noiseStep(input logic en);
        load_en   = en;
        load_addr = AW'($urandom_range(0, DEPTH - 1));
        load_data = randVec();
        @(posedge clk); #1;
        load_en   = 1'b0;
    endtask

    task automatic waitDone(input string name);
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                @(posedge clk); #1;
                return;
            end
        end
        tests++;
        fails++;
        $display("[TB] FAIL %s: done not seen within %0d cycles, expected a done pulse", name, WAIT_LIMIT);
    endtask

    task automatic applyStimulus(input int num, input logic lp, input int abort_d, input logic noise);
        int t;
        int n;
        num_vec   = (AW+1)'(num);
        loop_mode = lp;
        start     = 1'b1;
        @(posedge clk); #1;
        t     = cyc;
        start = 1'b0;
        n     = clampN(num);
        pushRun(t, n, lp, abort_d);
        if (n > 0 && abort_d > 0) begin
            repeat (abort_d - 1) noiseStep(noise);
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
        end else if (n > 0 && noise) begin
            repeat (n * HOLD - 1) noiseStep(1'b1);
        end
        waitDone("run_done");
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_vec_out"}, 64'(vec_out), 64'(0));
        checkOutput({tag, "_vec_valid"}, 64'(vec_valid), 64'(0));
        checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
        checkOutput({tag, "_done"}, 64'(done), 64'(0));
        checkOutput({tag, "_vec_index"}, 64'(vec_index), 64'(0));
        checkOutput({tag, "_pass_count"}, 64'(pass_count), 64'(0));
        checkOutput({tag, "_signature"}, 64'(signature), 64'(0));
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: still running at cycle %0d, expected completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        int num;
        int n;
        int ab;
        logic lp;
        logic noise;

        rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; abort = 1'b0; num_vec = '0; loop_mode = 1'b0;
        repeat (3) @(posedge clk); #1;
        checkReset("reset");
        rst    = 1'b0;
        mon_en = 1'b1;

        loadMem(0, 36'h1);
        loadMem(1, 36'h2);
        applyStimulus(2, 1'b0, 0, 1'b0);
        checkOutput("sig_basic", 64'(signature), 64'h00);

        loadMem(0, 36'h40);
        loadMem(1, 36'h0);
        applyStimulus(2, 1'b0, 0, 1'b0);
        checkOutput("sig_taps", 64'(signature), 64'h03);

        for (int i = 0; i < DEPTH; i++)
            loadMem(i, randVec());

        applyStimulus(20, 1'b0, 0, 1'b1);
        repeat (2) @(posedge clk); #1;
        checkOutput("sig_clamp_stable", 64'(signature), 64'(last_sig));

        applyStimulus(4, 1'b1, 10 * HOLD + 1, 1'b0);
        checkOutput("pass_loop_mid", 64'(pass_count), 64'(2));
        applyStimulus(4, 1'b1, 11 * HOLD, 1'b0);
        checkOutput("pass_loop_edge", 64'(pass_count), 64'(2));
        checkOutput("sig_loop_edge", 64'(signature), 64'(last_sig));

        applyStimulus(0, 1'b0, 0, 1'b0);
        checkOutput("sig_zero", 64'(signature), 64'h00);
        applyStimulus(0, 1'b1, 0, 1'b0);

        // start held high: second run may only begin once the FSM is back in IDLE
        num_vec   = (AW+1)'(2);
        loop_mode = 1'b0;
        start     = 1'b1;
        @(posedge clk); #1;
        t = cyc;
        pushRun(t, 2, 1'b0, 0);
        repeat (2 * HOLD + 2) @(posedge clk); #1;
        t = cyc;
        pushRun(t, 2, 1'b0, 0);
        start = 1'b0;
        waitDone("held_start_done");

        num_vec   = (AW+1)'(8);
        loop_mode = 1'b0;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pushStream(8, 5);
        repeat (4) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkReset("rst_mid");
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        checkOutput("rst_no_done", 64'(done), 64'(0));
        applyStimulus(8, 1'b0, 0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            if (r % 4 == 3)
                loadMem(int'($urandom_range(0, DEPTH - 1)), randVec());
            num   = int'($urandom_range(0, 31));
            n     = clampN(num);
            lp    = (n > 0) && ($urandom_range(0, 1) == 1);
            noise = 1'($urandom_range(0, 1));
            if (lp)
                ab = int'($urandom_range(1, 3 * n * HOLD + 4));
            else if (n > 0 && $urandom_range(0, 2) == 0)
                ab = int'($urandom_range(1, n * HOLD));
            else
                ab = 0;
            applyStimulus(num, lp, ab, noise);
        end

        repeat (4) @(posedge clk); #1;
        checkOutput("vec_q_empty", 64'(exp_vec_q.size()), 64'(0));
        checkOutput("done_q_empty", 64'(exp_done_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pattern_player_misr.md
# pattern_player_misr

Synthesisable stimulus/response engine for combinational benchmark cores (ISCAS-85 class, e.g. the 36-in/7-out c432).
- Holds a loadable vector memory and drives one vector per step onto the core's inputs.
- Compresses the core's outputs into a multiple-input signature register (MISR).
- Replaces file-based vector replay and per-cycle output logging with an on-chip run whose signature the aging experiments compare across cores and runs.

## Interface
- VEC_WIDTH, 36, bits per input vector (core input count)
- RESP_WIDTH, 7, bits of core response (core output count); also MISR width; ≥2
- DEPTH, 16, vector memory entries; power of two, ≥2
- HOLD_CYCLES, 1, cycles each vector is held before its response is sampled; ≥1
- MISR_POLY, 7'h03, feedback taps XORed in when the MISR MSB shifts out; RESP_WIDTH bits

- clk  in  1  sole clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- load_en  in  1  write load_data to vector memory at load_addr
- load_addr  in  log2(DEPTH)  write address
- load_data  in  VEC_WIDTH  write data
- start  in  1  begin a run (sampled in IDLE only)
- abort  in  1  terminate a run early
- num_vec  in  log2(DEPTH)+1  vectors per pass, sampled with start
- loop_mode  in  1  sampled with start; 1 = repeat passes until abort
- vec_out  out  VEC_WIDTH  vector driven to the core
- vec_valid  out  1  vec_out is an active stimulus
- resp_in  in  RESP_WIDTH  core response
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- vec_index  out  log2(DEPTH)  address of the vector currently applied
- pass_count  out  16  completed passes in the current run; wraps
- signature  out  RESP_WIDTH  MISR contents

## Operation
- States: IDLE, APPLY, DONE.
- **IDLE**
  - load_en writes memory. Memory is not reset.
  - start loads the run parameters, clears the MISR to 0, vec_index to 0, pass_count to 0 and the hold counter, then moves to APPLY.
  - Effective count N = min(num_vec, DEPTH).
  - If N = 0, go to DONE instead, with no vectors applied.
- **APPLY**
  - vec_out = mem[vec_index] and vec_valid = 1.
  - The hold counter counts 0..HOLD_CYCLES-1. On its last cycle the MISR updates:
    - sig_next = ((sig << 1) truncated to RESP_WIDTH) ^ (sig[MSB] ? MISR_POLY : 0) ^ resp_in.
  - After the update, vec_index advances.
  - After vector N-1:
    - If loop_mode = 0: go to DONE.
    - If loop_mode = 1: pass_count increments, vec_index wraps to 0, and the MISR keeps accumulating.
- **DONE**
  - done = 1 for one cycle, then return to IDLE.
- **Ignored and precedence rules**
  - load_en is ignored while busy.
  - start is ignored outside IDLE.
  - abort in APPLY goes to DONE at the next edge. The MISR is not updated on that edge, even if it is a sample cycle.
  - abort has priority over a simultaneous last-vector transition.
- **Reset values**
  - vec_out 0, vec_valid 0, busy 0, done 0, vec_index 0, pass_count 0, signature 0, state IDLE.
  - A reset in mid-run takes effect on that edge with no done pulse.

## Timing
- start high at edge T (IDLE):
  - From T+1: busy = 1, vec_valid = 1, vec_out = mem[0].
  - Vector k is driven for cycles T+1+k·HOLD_CYCLES through T+(k+1)·HOLD_CYCLES.
  - resp_in is sampled at the edge that closes that window. The core path must settle within HOLD_CYCLES cycles.
- Non-loop run completion:
  - done = 1 during cycle T+N·HOLD_CYCLES+1.
  - busy and vec_valid are 0 in that cycle.
  - vec_out holds the last vector.
  - signature is final and stays stable until the next start or rst.
- N = 0: done during T+1, signature 0, vec_valid never asserted.
- Vector memory is a registered read. Its address is precomputed so vec_out changes exactly on window boundaries.
- start pulses longer than one cycle do not retrigger. Only a start seen in IDLE counts.

## Test plan
- **Basic MISR, HOLD_CYCLES=1:** load mem[0..1]. The stub core returns 7'h01 then 7'h02. Pulse start with num_vec=2 → vec_valid for 2 cycles, done at T+3, signature 7'h00.
- **Feedback taps:** responses 7'h40 then 7'h00 → signature 7'h03 (MSB shifted out, MISR_POLY applied).
- **Hold and clamp, HOLD_CYCLES=3, num_vec=20, DEPTH=16:**
  - Each vector is stable for exactly 3 cycles.
  - 16 vectors are applied.
  - done at T+49.
  - load_en pulses during the run leave memory unchanged.
- **Loop and abort:** loop_mode=1, N=4, abort after 10 vectors →
  - pass_count = 2.
  - MISR equals the model over 10 responses.
  - done one cycle after abort.
  - An abort coinciding with a sample edge excludes that response.
- **Zero count and start:** num_vec=0 → done at T+1, signature 0. A held-high start retriggers only from IDLE.
- **Reset mid-run:** rst in cycle 5 of a run → all outputs at reset values the next cycle, no done pulse, memory contents preserved.
